// File: rtl/adder_arbiter.sv
// ============================================================================
// Module   : adder_arbiter
// Purpose  : Round-robin arbiter sharing one 4-bit adder among NUM_REQ
//            requesters through an IDLE -> ADD -> DONE handshake FSM.
//            Define ADDER_ARB_CARRY_EN to add the resp_carry output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [4*NUM_REQ-1:0]   op_a,
    input  logic [4*NUM_REQ-1:0]   op_b,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [2:0]             resp_id,
    output logic [3:0]             resp_sum,
`ifdef ADDER_ARB_CARRY_EN
    output logic                   resp_carry,
`endif
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [2:0] r_last;
    logic [2:0] r_id;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [3:0] r_sum;

    logic       w_found;
    logic [2:0] w_gnt;
    logic [3:0] w_a;
    logic [3:0] w_b;
    logic       w_handshake;

`ifdef ADDER_ARB_CARRY_EN
    logic [4:0] w_sum;
    logic       r_carry;
    assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
    assign resp_carry = r_carry;
`else
    logic [3:0] w_sum;
    assign w_sum = r_a + r_b;
`endif

    // Round-robin search: lowest offset from last_grant+1 wins, wrapping once.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_a     = '0;
        w_b     = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_found && req[j] &&
                    ((int'(r_last) + off == j) || (int'(r_last) + off - NUM_REQ == j))) begin
                    w_found = 1'b1;
                    w_gnt   = 3'(j);
                    w_a     = op_a[4*j +: 4];
                    w_b     = op_b[4*j +: 4];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Reset gates ack so an abandoned DONE never pulses a requester.
    always_comb begin
        w_next      = r_state;
        resp_valid  = 1'b0;
        busy        = 1'b1;
        w_handshake = 1'b0;
        ack         = '0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_found) begin
                    w_next = S_ADD;
                end
            end
            S_ADD: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_handshake = 1'b1;
                    w_next      = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        for (int j = 0; j < NUM_REQ; j++) begin
            ack[j] = w_handshake && rst_n && (r_id == 3'(j));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last  <= 3'(NUM_REQ - 1);
            r_id    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
`ifdef ADDER_ARB_CARRY_EN
            r_carry <= 1'b0;
`endif
        end else begin
            if (r_state == S_IDLE && w_found) begin
                r_id <= w_gnt;
                r_a  <= w_a;
                r_b  <= w_b;
            end
            if (r_state == S_ADD) begin
                r_sum   <= w_sum[3:0];
`ifdef ADDER_ARB_CARRY_EN
                r_carry <= w_sum[4];
`endif
            end
            if (w_handshake) begin
                r_last <= r_id;
            end
        end
    end

    assign resp_id  = r_id;
    assign resp_sum = r_sum;

endmodule

`default_nettype wire

// File: tb/tb_adder_arbiter.sv
// ============================================================================
// Module   : tb_adder_arbiter
// Purpose  : Directed-vector scoreboard bench for adder_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_arbiter;

    localparam int NUM_REQ = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_REQ-1:0]   req = '0;
    logic [4*NUM_REQ-1:0] op_a = '0;
    logic [4*NUM_REQ-1:0] op_b = '0;
    logic [NUM_REQ-1:0]   ack;
    logic                 resp_valid;
    logic                 resp_ready = 1'b0;
    logic [2:0]           resp_id;
    logic [3:0]           resp_sum;
    logic                 resp_carry;
    logic                 busy;

    typedef struct packed {
        logic [2:0] id;
        logic [3:0] sum;
        logic       carry;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    adder_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .op_a       (op_a),
        .op_b       (op_b),
        .ack        (ack),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
`ifdef ADDER_ARB_CARRY_EN
        .resp_carry (resp_carry),
`endif
        .busy       (busy)
    );

`ifndef ADDER_ARB_CARRY_EN
    assign resp_carry = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input int id, input int a, input int b);
        exp_t       e;
        logic [4:0] s;
        s       = 5'(a + b);
        e.id    = 3'(id);
        e.sum   = s[3:0];
        e.carry = s[4];
        sb.push_back(e);
    endtask

    task automatic set_op(input int i, input int a, input int b);
        op_a[4*i +: 4] = 4'(a);
        op_b[4*i +: 4] = 4'(b);
    endtask

    task automatic wait_valid(input string nm);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk);
            #1;
            if (resp_valid === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: resp_valid actual=0 required=1 (timeout)", nm);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completed handshake pops and checks one expectation.
    initial begin
        exp_t               e;
        logic [NUM_REQ-1:0] exp_ack;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL mon_unexpected: resp_id=%0d resp_sum=%0d with empty scoreboard",
                                 resp_id, resp_sum);
                    end else begin
                        e       = sb.pop_front();
                        exp_ack = NUM_REQ'(1) << e.id;
                        check("mon_id", 32'(resp_id), 32'(e.id));
                        check("mon_sum", 32'(resp_sum), 32'(e.sum));
                        check("mon_ack", 32'(ack), 32'(exp_ack));
`ifdef ADDER_ARB_CARRY_EN
                        check("mon_carry", 32'(resp_carry), 32'(e.carry));
`endif
                    end
                end else begin
                    check("mon_ack_idle", 32'(ack), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        // Reset state
        rst_n = 1'b0;
        step();
        step();
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_id", 32'(resp_id), 32'd0);
        check("rst_sum", 32'(resp_sum), 32'd0);

        // Single request, latency of two cycles
        rst_n      = 1'b1;
        req        = 4'b0001;
        set_op(0, 3, 4);
        resp_ready = 1'b1;
        push(0, 3, 4);
        step();
        check("lat_add_busy", 32'(busy), 32'd1);
        check("lat_add_valid", 32'(resp_valid), 32'd0);
        req = '0;
        step();
        check("lat_done_valid", 32'(resp_valid), 32'd1);
        check("lat_done_sum", 32'(resp_sum), 32'd7);
        step();
        check("lat_back_idle", 32'(busy), 32'd0);

        // All requesting: order 0,1,2,3,0 at three-cycle spacing
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req   = 4'b1111;
        set_op(0, 1, 2);
        set_op(1, 9, 8);
        set_op(2, 15, 15);
        set_op(3, 7, 8);
        push(0, 1, 2);
        push(1, 9, 8);
        push(2, 15, 15);
        push(3, 7, 8);
        push(0, 1, 2);
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_valid("rr_valid");
            if (k > 0) check("rr_spacing", 32'(cyc - prev), 32'd3);
            prev = cyc;
            if (k == 4) req = '0;
            step();
        end

        // Back-pressure: five stalled DONE cycles
        resp_ready = 1'b0;
        req        = 4'b0010;
        set_op(1, 4, 5);
        push(1, 4, 5);
        wait_valid("stall_valid");
        req = '0;
        for (int k = 0; k < 5; k++) begin
            check("stall_valid_hold", 32'(resp_valid), 32'd1);
            check("stall_id_hold", 32'(resp_id), 32'd1);
            check("stall_sum_hold", 32'(resp_sum), 32'd9);
            check("stall_no_ack", 32'(ack), 32'd0);
            step();
        end
        resp_ready = 1'b1;
        #1;
        check("stall_ack_rise", 32'(ack), 32'b0010);
        step();
        check("stall_release", 32'(resp_valid), 32'd0);

        // Requester withdraws and changes operands while in ADD
        req = 4'b0100;
        set_op(2, 6, 7);
        push(2, 6, 7);
        step();
        req  = '0;
        op_a = 16'hFFFF;
        op_b = 16'hFFFF;
        wait_valid("inflight_valid");
        check("inflight_sum", 32'(resp_sum), 32'd13);
        step();

        // Reset in DONE abandons the transaction
        resp_ready = 1'b0;
        req        = 4'b1000;
        set_op(3, 1, 1);
        wait_valid("abort_valid");
        req = '0;
        check("abort_id", 32'(resp_id), 32'd3);
        rst_n      = 1'b0;
        resp_ready = 1'b1;
        #1;
        check("abort_no_ack", 32'(ack), 32'd0);
        @(posedge clk);
        #1;
        check("abort_valid_zero", 32'(resp_valid), 32'd0);
        check("abort_busy_zero", 32'(busy), 32'd0);
        check("abort_id_zero", 32'(resp_id), 32'd0);
        check("abort_sum_zero", 32'(resp_sum), 32'd0);
        check("abort_ack_zero", 32'(ack), 32'd0);
        rst_n = 1'b1;
        req   = 4'b1111;
        set_op(0, 2, 14);
        push(0, 2, 14);
        wait_valid("post_rst_valid");
        req = '0;
        check("post_rst_id", 32'(resp_id), 32'd0);
        step();

        for (int k = 0; k < 10 && sb.size() != 0; k++) step();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
